// File: rtl/instr_fetch_buffer_if.sv
// Fetch-buffer bus bundle: PC request side, instruction-memory port,
// decode-side handshake and the performance counters.
// slave  = the fetch buffer itself, master = the surrounding pipeline.
interface instr_fetch_buffer_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] pc_in;
  logic                  pc_valid;
  logic                  pc_ready;
  logic                  flush;
  logic                  imem_en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic [15:0]           perf_stall;
  logic [15:0]           perf_flush;

  modport slave (
    input  pc_in, pc_valid, flush, imem_rdata, instr_ready,
    output pc_ready, imem_en, imem_addr, instr_valid, instr_data, instr_pc,
           perf_stall, perf_flush
  );

  modport master (
    output pc_in, pc_valid, flush, imem_rdata, instr_ready,
    input  pc_ready, imem_en, imem_addr, instr_valid, instr_data, instr_pc,
           perf_stall, perf_flush
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues PC reads to a synchronous instruction
// memory, captures {word, pc} into a small FIFO and hands instructions to
// decode over valid/ready. flush drops everything buffered or in flight.
// Optional feature macro: IFB_PERF_CNT_EN enables the saturating stall and
// flush counters; without it perf_stall/perf_flush are constant 0.
module instr_fetch_buffer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_buffer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // FIFO storage (never reset; only entries between rd_ptr and wr_ptr matter)
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] occupancy;

  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] pend_pc_p1;

  logic fire;
  logic push;
  logic pop;

  // ---- stage p0: issue to instruction memory ----
  // Space is reserved for the in-flight read, so a return can always be stored.
  assign occupancy    = count + {{(CNT_W-1){1'b0}}, vld_p1};
  assign bus.pc_ready = !bus.flush && (occupancy < DEPTH_C);
  assign fire         = bus.pc_valid && bus.pc_ready;
  assign bus.imem_en   = fire;
  assign bus.imem_addr = bus.pc_in;

  // ---- stage p1: memory return into FIFO, head to decode ----
  assign push = vld_p1 && !bus.flush;
  assign bus.instr_valid = (count != '0);
  assign bus.instr_data  = data_mem[rd_ptr];
  assign bus.instr_pc    = pc_mem[rd_ptr];
  assign pop  = bus.instr_valid && bus.instr_ready && !bus.flush;

  // Occupancy update: simultaneous push and pop leave count unchanged.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_ONE;
    end else if (pop && !push) begin
      count_nxt = count - CNT_ONE;
    end
  end

  // Control state: pointers, occupancy and in-flight flag; flush outranks all.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_p1 <= 1'b0;
    end else if (bus.flush) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= fire;
      count  <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Datapath: remember the issued PC and store returned words with their PC.
  always_ff @(posedge clk) begin
    if (fire) begin
      pend_pc_p1 <= bus.pc_in;
    end
    if (push) begin
      data_mem[wr_ptr] <= bus.imem_rdata;
      pc_mem[wr_ptr]   <= pend_pc_p1;
    end
  end

`ifdef IFB_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating counters of back-pressured fetch cycles and flush cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.pc_valid && !bus.pc_ready) stall_cnt <= sat_inc(stall_cnt);
      if (bus.flush)                     flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign bus.perf_stall = stall_cnt;
  assign bus.perf_flush = flush_cnt;
`else
  assign bus.perf_stall = 16'h0000;
  assign bus.perf_flush = 16'h0000;
`endif

  // Reserving space at issue time means the FIFO can never overfill.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (count <= DEPTH_C) && (occupancy <= DEPTH_C));

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: a hand-derived vector table for
// streaming, back-pressure and flush, plus hand-written sequences for a full
// FIFO, pointer wrap, random traffic and reset mid-stream. A queue scoreboard
// predicts every output on every cycle.
module tb_instr_fetch_buffer;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  instr_fetch_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {8'hA5, a ^ 12'h5C3, a};
  endfunction

  // Synchronous instruction memory: data one cycle after imem_en.
  always @(posedge clk) begin
    if (ifc.imem_en) ifc.imem_rdata <= mem_word(ifc.imem_addr);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard model ----------------
  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          m_q[$];
  bit            m_inf = 1'b0;
  logic [AW-1:0] m_pend = '0;
  int            m_stall = 0;
  int            m_flush = 0;

  logic          cur_pv, cur_rdy, cur_fl, cur_rst;
  logic [AW-1:0] cur_pc;

  function automatic bit model_pr(input logic fl);
    return !fl && ((m_q.size() + int'(m_inf)) < DEPTH);
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_inf = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic apply(input logic pv, input logic [AW-1:0] pc, input logic rdy,
                       input logic fl, input logic rst);
    cur_pv = pv; cur_pc = pc; cur_rdy = rdy; cur_fl = fl; cur_rst = rst;
    ifc.pc_valid    = pv;
    ifc.pc_in       = pc;
    ifc.instr_ready = rdy;
    ifc.flush       = fl;
    reset           = rst;
    #2;
  endtask

  // Compare every output against the model, advance the model, clock once.
  task automatic model_step();
    bit pr, fire;
    pr   = model_pr(cur_fl);
    fire = cur_pv && pr;
    chk("pc_ready", {31'd0, ifc.pc_ready}, {31'd0, pr});
    chk("imem_en", {31'd0, ifc.imem_en}, {31'd0, fire});
    if (fire) chk("imem_addr", {20'd0, ifc.imem_addr}, {20'd0, cur_pc});
    chk("instr_valid", {31'd0, ifc.instr_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("instr_pc", {20'd0, ifc.instr_pc}, {20'd0, m_q[0].pc});
      chk("instr_data", ifc.instr_data, m_q[0].d);
    end
    chk("perf_stall", {16'd0, ifc.perf_stall}, m_stall);
    chk("perf_flush", {16'd0, ifc.perf_flush}, m_flush);
    if (cur_rst) begin
      model_clear();
    end else begin
`ifdef IFB_PERF_CNT_EN
      if (cur_pv && !pr && m_stall < 65535) m_stall++;
      if (cur_fl && m_flush < 65535) m_flush++;
`endif
      if (cur_fl) begin
        m_q.delete();
      end else begin
        if (m_q.size() != 0 && cur_rdy) void'(m_q.pop_front());
        if (m_inf) m_q.push_back('{pc: m_pend, d: mem_word(m_pend)});
      end
      m_inf = fire;
      if (fire) m_pend = cur_pc;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          pv;
    logic [AW-1:0] pc;
    logic          rdy;
    logic          fl;
    logic          exp_pr;
    logic          exp_iv;
    logic [AW-1:0] exp_pc;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  function automatic vec_t mk(input bit pv, input int pc, input bit rdy, input bit fl,
                              input bit pr, input bit iv, input int epc);
    vec_t v;
    v.pv = pv; v.pc = AW'(pc); v.rdy = rdy; v.fl = fl;
    v.exp_pr = pr; v.exp_iv = iv; v.exp_pc = AW'(epc);
    return v;
  endfunction

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      apply(tbl[i].pv, tbl[i].pc, tbl[i].rdy, tbl[i].fl, 1'b0);
      chk($sformatf("row%0d pc_ready", i), {31'd0, ifc.pc_ready}, {31'd0, tbl[i].exp_pr});
      chk($sformatf("row%0d instr_valid", i), {31'd0, ifc.instr_valid}, {31'd0, tbl[i].exp_iv});
      if (tbl[i].exp_iv) begin
        chk($sformatf("row%0d instr_pc", i), {20'd0, ifc.instr_pc}, {20'd0, tbl[i].exp_pc});
        chk($sformatf("row%0d instr_data", i), ifc.instr_data, mem_word(tbl[i].exp_pc));
      end
      model_step();
    end
  endtask

  initial begin
    logic [AW-1:0] pc_cur;
    bit            pend;
    bit            pv, rdy, fl;
    int            exp_perf;

    // Streaming with decode always ready: valid two cycles after first issue.
    tbl[0]  = mk(1, 'h000, 1, 0, 1, 0, 'h000);
    tbl[1]  = mk(1, 'h001, 1, 0, 1, 0, 'h000);
    tbl[2]  = mk(1, 'h002, 1, 0, 1, 1, 'h000);
    tbl[3]  = mk(0, 'h003, 1, 0, 1, 1, 'h001);
    tbl[4]  = mk(0, 'h003, 1, 0, 1, 1, 'h002);
    tbl[5]  = mk(0, 'h003, 1, 0, 1, 0, 'h000);
    // Decode stalled: exactly four fetches accepted, then drained in order.
    tbl[6]  = mk(1, 'h010, 0, 0, 1, 0, 'h000);
    tbl[7]  = mk(1, 'h011, 0, 0, 1, 0, 'h000);
    tbl[8]  = mk(1, 'h012, 0, 0, 1, 1, 'h010);
    tbl[9]  = mk(1, 'h013, 0, 0, 1, 1, 'h010);
    tbl[10] = mk(1, 'h014, 0, 0, 0, 1, 'h010);
    tbl[11] = mk(1, 'h014, 0, 0, 0, 1, 'h010);
    tbl[12] = mk(1, 'h014, 1, 0, 0, 1, 'h010);
    tbl[13] = mk(1, 'h014, 1, 0, 1, 1, 'h011);
    tbl[14] = mk(0, 'h014, 1, 0, 1, 1, 'h012);
    tbl[15] = mk(0, 'h014, 1, 0, 1, 1, 'h013);
    tbl[16] = mk(0, 'h014, 1, 0, 1, 1, 'h014);
    tbl[17] = mk(0, 'h014, 1, 0, 1, 0, 'h000);
    // Flush while 3,4 are buffered and 5 is in flight; redirect to 0x40.
    tbl[18] = mk(1, 'h003, 0, 0, 1, 0, 'h000);
    tbl[19] = mk(1, 'h004, 0, 0, 1, 0, 'h000);
    tbl[20] = mk(1, 'h005, 0, 0, 1, 1, 'h003);
    tbl[21] = mk(1, 'h040, 0, 1, 0, 1, 'h003);
    tbl[22] = mk(1, 'h040, 0, 0, 1, 0, 'h000);
    tbl[23] = mk(0, 'h040, 0, 0, 1, 0, 'h000);
    tbl[24] = mk(0, 'h040, 1, 0, 1, 1, 'h040);
    tbl[25] = mk(0, 'h040, 1, 0, 1, 0, 'h000);

    // Reset and reset-state check.
    apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    apply(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("reset instr_valid", {31'd0, ifc.instr_valid}, 32'd0);
    chk("reset pc_ready", {31'd0, ifc.pc_ready}, 32'd1);
    chk("reset perf_stall", {16'd0, ifc.perf_stall}, 32'd0);
    chk("reset perf_flush", {16'd0, ifc.perf_flush}, 32'd0);
    model_step();

    run_rows(0, 17);
`ifdef IFB_PERF_CNT_EN
    exp_perf = 3;
`else
    exp_perf = 0;
`endif
    apply(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("perf_stall after backpressure", {16'd0, ifc.perf_stall}, exp_perf);
    model_step();

    run_rows(18, 25);
`ifdef IFB_PERF_CNT_EN
    exp_perf = 1;
`else
    exp_perf = 0;
`endif
    apply(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("perf_flush after flush", {16'd0, ifc.perf_flush}, exp_perf);
    model_step();

    // Full FIFO, then drain with continuous fetch: returns and pops coincide
    // and pointers wrap several times.
    pc_cur = 12'h200;
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, pc_cur, 1'b0, 1'b0, 1'b0);
      if (model_pr(1'b0)) pc_cur = pc_cur + 12'd1;
      model_step();
    end
    apply(1'b1, pc_cur, 1'b0, 1'b0, 1'b0);
    chk("full pc_ready", {31'd0, ifc.pc_ready}, 32'd0);
    chk("full instr_pc", {20'd0, ifc.instr_pc}, 32'h200);
    model_step();
    for (int i = 0; i < 14; i++) begin
      apply(1'b1, pc_cur, 1'b1, 1'b0, 1'b0);
      if (model_pr(1'b0)) pc_cur = pc_cur + 12'd1;
      model_step();
    end

    // Random traffic with occasional flushes; PC holds while not accepted.
    pend = 1'b0;
    for (int i = 0; i < 300; i++) begin
      fl  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      pv  = pend || ($urandom_range(0, 3) != 0);
      if (fl) pc_cur = 12'(($urandom_range(0, 63)) << 4);
      apply(pv, pc_cur, rdy, fl, 1'b0);
      if (pv && model_pr(fl)) begin
        pc_cur = pc_cur + 12'd1;
        pend = 1'b0;
      end else begin
        pend = pv && !fl;
      end
      model_step();
    end

    // Reset mid-stream with buffered and in-flight fetches.
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 12'h300 + 12'(i), 1'b0, 1'b0, 1'b0);
      model_step();
    end
    apply(1'b1, 12'h305, 1'b0, 1'b0, 1'b1);
    model_step();
    apply(1'b1, 12'h305, 1'b0, 1'b0, 1'b0);
    chk("post-reset instr_valid", {31'd0, ifc.instr_valid}, 32'd0);
    chk("post-reset pc_ready", {31'd0, ifc.pc_ready}, 32'd1);
    chk("post-reset perf_stall", {16'd0, ifc.perf_stall}, 32'd0);
    chk("post-reset perf_flush", {16'd0, ifc.perf_flush}, 32'd0);
    model_step();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 12'h305, 1'b1, 1'b0, 1'b0);
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
